regfile_sb: RTL and testbench

Parametrised register file with a pending-write scoreboard, the successor to the fixed 15×64 Y86 register file. It keeps the two-read / two-write (E and M) port model of the Y86 writeback stage. Register width, register count and bypass behaviour are parameters, and a per-register outstanding-write counter lets the pipelined decode stage detect read-after-write hazards.

---
 rtl/y86_pkg.sv | 28 ++
 rtl/rf_cell.sv | 50 +++++
 rtl/regfile_sb.sv | 141 ++++++++++++++
 tb/tb_regfile_sb.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 definitions: architectural register indices and default
// register-file geometry.
package y86_pkg;

    localparam int Y86_W    = 64;
    localparam int Y86_NREG = 15;
    localparam int Y86_AW   = 4;

    typedef enum logic [3:0] {
        R_RAX  = 4'd0,
        R_RCX  = 4'd1,
        R_RDX  = 4'd2,
        R_RBX  = 4'd3,
        R_RSP  = 4'd4,
        R_RBP  = 4'd5,
        R_RSI  = 4'd6,
        R_RDI  = 4'd7,
        R_R8   = 4'd8,
        R_R9   = 4'd9,
        R_R10  = 4'd10,
        R_R11  = 4'd11,
        R_R12  = 4'd12,
        R_R13  = 4'd13,
        R_R14  = 4'd14,
        R_NONE = 4'd15
    } reg_idx_e;

endpackage

// File: rtl/rf_cell.sv
// One architectural register: data flop with write enable plus a saturating
// pending-write counter. err pulses when an increment hits the ceiling or a
// decrement hits zero; the counter holds its value in both cases.
module rf_cell #(
    parameter int             W         = 64,
    parameter int             PCW       = 2,
    parameter logic [W-1:0]   RESET_VAL = {W{1'b0}}
) (
    input  logic             clk,
    input  logic             res,
    input  logic             we,
    input  logic [W-1:0]     wdata,
    input  logic             inc,
    input  logic             dec,
    output logic [W-1:0]     data,
    output logic [PCW-1:0]   pend,
    output logic             err
);

    localparam logic [PCW-1:0] PEND_MAX  = {PCW{1'b1}};
    localparam logic [PCW-1:0] PEND_ZERO = {PCW{1'b0}};

    // Data register: load on write enable, reset to RESET_VAL.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            data <= RESET_VAL;
        end else if (we) begin
            data <= wdata;
        end else begin
            data <= data;
        end
    end

    // Pending-write counter: net +1 on issue, -1 on completion, saturating.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            pend <= PEND_ZERO;
        end else begin
            case ({inc, dec})
                2'b10:   pend <= (pend != PEND_MAX)  ? pend + {{(PCW-1){1'b0}}, 1'b1} : pend;
                2'b01:   pend <= (pend != PEND_ZERO) ? pend - {{(PCW-1){1'b0}}, 1'b1} : pend;
                default: pend <= pend;
            endcase
        end
    end

    assign err = (inc && !dec && (pend == PEND_MAX)) ||
                 (dec && !inc && (pend == PEND_ZERO));

endmodule

// File: rtl/regfile_sb.sv
// Two-read / two-write (E, M) register file with per-register pending-write
// scoreboard. M wins over E on a shared destination, both for the update and
// for same-cycle forwarding. Reads and busy flags are combinational.
module regfile_sb
    import y86_pkg::*;
#(
    parameter int           W         = Y86_W,
    parameter int           NREG      = Y86_NREG,
    parameter int           AW        = Y86_AW,
    parameter int           RNONE     = int'(R_NONE),
    parameter int           BYPASS    = 1,
    parameter int           PCW       = 2,
    parameter logic [W-1:0] RESET_VAL = {W{1'b0}}
) (
    input  logic              clk,
    input  logic              res,
    input  logic [AW-1:0]     srcA,
    input  logic [AW-1:0]     srcB,
    output logic [W-1:0]      valA,
    output logic [W-1:0]      valB,
    output logic              busyA,
    output logic              busyB,
    input  logic [AW-1:0]     dstE,
    input  logic [W-1:0]      valE,
    input  logic [AW-1:0]     dstM,
    input  logic [W-1:0]      valM,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_dst,
    output logic              sb_err,
    output logic [W*NREG-1:0] regs
);

    localparam logic [AW-1:0] NREG_IDX = AW'(NREG);

    if ((RNONE < NREG) || ((2 ** AW) <= NREG)) begin : g_cfg_bad
        $error("regfile_sb: RNONE must be >= NREG and 2**AW must exceed NREG");
    end

    logic             we_e_ok_s;
    logic             we_m_ok_s;
    logic             iss_ok_s;
    logic [W-1:0]     data_s [NREG];
    logic [PCW-1:0]   pend_s [NREG];
    logic [NREG-1:0]  err_s;
    logic             sb_err_r;

    assign we_e_ok_s = (dstE < NREG_IDX);
    assign we_m_ok_s = (dstM < NREG_IDX);
    assign iss_ok_s  = iss_en && (iss_dst < NREG_IDX);

    for (genvar i = 0; i < NREG; i++) begin : g_cell
        logic hit_e_s;
        logic hit_m_s;
        logic inc_s;

        assign hit_e_s = we_e_ok_s && (dstE == AW'(i));
        assign hit_m_s = we_m_ok_s && (dstM == AW'(i));
        assign inc_s   = iss_ok_s  && (iss_dst == AW'(i));

        rf_cell #(
            .W         (W),
            .PCW       (PCW),
            .RESET_VAL (RESET_VAL)
        ) u_cell (
            .clk   (clk),
            .res   (res),
            .we    (hit_e_s || hit_m_s),
            .wdata (hit_m_s ? valM : valE),
            .inc   (inc_s),
            .dec   (hit_e_s || hit_m_s),
            .data  (data_s[i]),
            .pend  (pend_s[i]),
            .err   (err_s[i])
        );

        assign regs[i*W +: W] = data_s[i];
    end

    logic [AW-1:0] src_s  [2];
    logic [W-1:0]  val_s  [2];
    logic          busy_s [2];

    assign src_s[0] = srcA;
    assign src_s[1] = srcB;
    assign valA     = val_s[0];
    assign valB     = val_s[1];
    assign busyA    = busy_s[0];
    assign busyB    = busy_s[1];

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic [W-1:0]   rd_data_s;
        logic [PCW-1:0] rd_pend_s;
        logic           hit_e_s;
        logic           hit_m_s;

        assign hit_e_s = we_e_ok_s && (dstE == src_s[p]);
        assign hit_m_s = we_m_ok_s && (dstM == src_s[p]);

        // Read mux with M-over-E forwarding and scoreboard busy for this port.
        always_comb begin
            rd_data_s = {W{1'b0}};
            rd_pend_s = {PCW{1'b0}};
            for (int i = 0; i < NREG; i++) begin
                if (src_s[p] == AW'(i)) begin
                    rd_data_s = data_s[i];
                    rd_pend_s = pend_s[i];
                end else begin
                end
            end

            if ((BYPASS != 0) && hit_m_s) begin
                val_s[p] = valM;
            end else if ((BYPASS != 0) && hit_e_s) begin
                val_s[p] = valE;
            end else begin
                val_s[p] = rd_data_s;
            end

            if (!res) begin
                busy_s[p] = 1'b0;
            end else if (BYPASS != 0) begin
                // A completing write retires one outstanding count right now.
                busy_s[p] = (rd_pend_s != PCW'(hit_e_s || hit_m_s));
            end else begin
                busy_s[p] = (rd_pend_s != {PCW{1'b0}});
            end
        end
    end

    // Sticky scoreboard error: any cell over/underflow, cleared only by reset.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            sb_err_r <= 1'b0;
        end else begin
            sb_err_r <= sb_err_r | (|err_s);
        end
    end

    assign sb_err = sb_err_r;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one instance with forwarding, one without,
// sharing the same stimulus.
module tb_regfile_sb;

    logic          clk;
    logic          res;
    logic [3:0]    srcA, srcB, dstE, dstM, iss_dst;
    logic [63:0]   valE, valM;
    logic          iss_en;

    logic [63:0]   valA_b, valB_b, valA_n, valB_n;
    logic          busyA_b, busyB_b, busyA_n, busyB_n;
    logic          sb_err_b, sb_err_n;
    logic [959:0]  regs_b, regs_n;

    int n_chk;
    int n_pass;

    regfile_sb #(.BYPASS(1)) dut (
        .clk(clk), .res(res), .srcA(srcA), .srcB(srcB),
        .valA(valA_b), .valB(valB_b), .busyA(busyA_b), .busyB(busyB_b),
        .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
        .iss_en(iss_en), .iss_dst(iss_dst), .sb_err(sb_err_b), .regs(regs_b)
    );

    regfile_sb #(.BYPASS(0)) dut_nb (
        .clk(clk), .res(res), .srcA(srcA), .srcB(srcB),
        .valA(valA_n), .valB(valB_n), .busyA(busyA_n), .busyB(busyB_n),
        .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
        .iss_en(iss_en), .iss_dst(iss_dst), .sb_err(sb_err_n), .regs(regs_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rg(input logic [959:0] v, input int i);
        return v[i*64 +: 64];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        dstE    = 4'd15;
        dstM    = 4'd15;
        iss_en  = 1'b0;
        iss_dst = 4'd15;
    endtask

    // Pulse reset mid-cycle, check asynchronous clearing, release before an edge.
    task automatic pulse_reset(input string tag);
        res = 1'b0;
        #2;
        check({tag, "_rst_regs"},  64'(|regs_b), 64'd0);
        check({tag, "_rst_err_b"}, 64'(sb_err_b), 64'd0);
        check({tag, "_rst_err_n"}, 64'(sb_err_n), 64'd0);
        tick;
        res = 1'b1;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        res    = 1'b0;
        srcA   = 4'd15;
        srcB   = 4'd15;
        valE   = 64'd0;
        valM   = 64'd0;
        idle;

        // Reset state
        tick; tick; tick;
        check("rst_regs_b", 64'(|regs_b), 64'd0);
        check("rst_regs_n", 64'(|regs_n), 64'd0);
        check("rst_busyA",  64'(busyA_b), 64'd0);
        check("rst_busyB",  64'(busyB_b), 64'd0);
        check("rst_err",    64'(sb_err_b), 64'd0);
        res = 1'b1;
        tick;

        // E/M conflict on register 4, preceded by one issue so the count stays clean
        srcA = 4'd4; iss_en = 1'b1; iss_dst = 4'd4;
        tick; idle;
        check("em_busy_pre_b", 64'(busyA_b), 64'd1);
        check("em_busy_pre_n", 64'(busyA_n), 64'd1);
        dstE = 4'd4; valE = 64'h11; dstM = 4'd4; valM = 64'h22;
        #1;
        check("em_fwd_b",    valA_b, 64'h22);
        check("em_fwd_n",    valA_n, 64'h0);
        check("em_busy_b",   64'(busyA_b), 64'd0);
        check("em_busy_n",   64'(busyA_n), 64'd1);
        tick; idle; #1;
        check("em_reg4_b",   rg(regs_b, 4), 64'h22);
        check("em_reg4_n",   rg(regs_n, 4), 64'h22);
        check("em_rd_n",     valA_n, 64'h22);
        check("em_busy_post",64'(busyA_n), 64'd0);
        check("em_err",      64'(sb_err_b), 64'd0);

        // Bypass on port B, E write to register 3
        srcB = 4'd3; iss_en = 1'b1; iss_dst = 4'd3;
        tick; idle;
        dstE = 4'd3; valE = 64'hDEAD;
        #1;
        check("byp_valB_b", valB_b, 64'hDEAD);
        check("byp_valB_n", valB_n, 64'h0);
        tick; idle; #1;
        check("byp_valB_n_next", valB_n, 64'hDEAD);
        check("byp_err", 64'(sb_err_b), 64'd0);

        // Scoreboard sequencing on register 2
        srcA = 4'd2; iss_en = 1'b1; iss_dst = 4'd2;
        tick; tick; idle; #1;
        check("sb_busy2_b", 64'(busyA_b), 64'd1);
        check("sb_busy2_n", 64'(busyA_n), 64'd1);
        dstM = 4'd2; valM = 64'h5;
        #1;
        check("sb_w1_busy_b", 64'(busyA_b), 64'd1);
        tick; idle; #1;
        check("sb_w1_busy_n", 64'(busyA_n), 64'd1);
        iss_en = 1'b1; iss_dst = 4'd2; dstM = 4'd2; valM = 64'h6;
        tick; idle; #1;
        check("sb_conc_busy_n", 64'(busyA_n), 64'd1);
        check("sb_conc_reg2",   rg(regs_b, 2), 64'h6);
        dstM = 4'd2; valM = 64'h7;
        #1;
        check("sb_last_busy_b", 64'(busyA_b), 64'd0);
        check("sb_last_busy_n", 64'(busyA_n), 64'd1);
        tick; idle; #1;
        check("sb_done_busy_b", 64'(busyA_b), 64'd0);
        check("sb_done_busy_n", 64'(busyA_n), 64'd0);
        check("sb_done_reg2",   rg(regs_b, 2), 64'h7);
        check("sb_done_err",    64'(sb_err_b), 64'd0);

        // Saturation: four issues to 5 with a 2-bit counter
        srcA = 4'd5; iss_en = 1'b1; iss_dst = 4'd5;
        tick; tick; tick; idle; #1;
        check("sat_err_3", 64'(sb_err_b), 64'd0);
        iss_en = 1'b1; iss_dst = 4'd5;
        tick; idle; #1;
        check("sat_err_4", 64'(sb_err_b), 64'd1);
        dstE = 4'd5; valE = 64'h55;
        tick; tick; idle; #1;
        check("sat_busy_after2", 64'(busyA_n), 64'd1);
        dstE = 4'd5; valE = 64'h55;
        tick; idle; #1;
        check("sat_busy_after3", 64'(busyA_n), 64'd0);
        pulse_reset("sat");
        check("sat_reg2_cleared", rg(regs_b, 2), 64'h0);

        // Underflow: write to 7 with nothing pending
        srcA = 4'd7; dstE = 4'd7; valE = 64'h77;
        tick; idle; #1;
        check("und_err_b",  64'(sb_err_b), 64'd1);
        check("und_err_n",  64'(sb_err_n), 64'd1);
        check("und_busy_n", 64'(busyA_n), 64'd0);
        check("und_reg7",   rg(regs_b, 7), 64'h77);
        pulse_reset("und");

        // Invalid indices everywhere
        srcA = 4'd15; dstE = 4'd15; valE = 64'hAA; dstM = 4'd15; valM = 64'hBB;
        iss_en = 1'b1; iss_dst = 4'd15;
        #1;
        check("inv_valA",  valA_b, 64'h0);
        check("inv_busyA", 64'(busyA_b), 64'd0);
        tick; idle; #1;
        check("inv_regs_b", 64'(|regs_b), 64'd0);
        check("inv_regs_n", 64'(|regs_n), 64'd0);
        check("inv_err",    64'(sb_err_b), 64'd0);

        // Highest valid index
        srcB = 4'd14; iss_en = 1'b1; iss_dst = 4'd14;
        tick; idle;
        dstE = 4'd14; valE = 64'hE;
        tick; idle; #1;
        check("top_reg14", rg(regs_b, 14), 64'hE);
        check("top_valB",  valB_n, 64'hE);
        check("top_err",   64'(sb_err_b), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
